// File: rtl/wb_lsu_if.sv
// Bundles the CPU-side request/response and Wishbone signals of wb_lsu.
// Latency: n/a (wires only).
// Backpressure: n/a; o_busy from the LSU tells the requester when i_req is ignored.
// Ports: CPU side i_req/i_we/i_size/i_signed/i_addr/i_data -> o_busy/o_done/o_error/
//        o_err_code/o_rdata; bus side o_wb_* out, i_wb_dat/i_wb_ack/i_wb_err in.
interface wb_lsu_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();
    localparam int NB = DATA_W / 8;

    // CPU execute-stage side
    logic              i_req;
    logic              i_we;
    logic [1:0]        i_size;
    logic              i_signed;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_data;
    logic              o_busy;
    logic              o_done;
    logic              o_error;
    logic [1:0]        o_err_code;
    logic [DATA_W-1:0] o_rdata;

    // Wishbone side
    logic [ADDR_W-1:0] o_wb_addr;
    logic              o_wb_cyc;
    logic              o_wb_stb;
    logic              o_wb_we;
    logic [NB-1:0]     o_wb_sel;
    logic [DATA_W-1:0] o_wb_dat;
    logic [DATA_W-1:0] i_wb_dat;
    logic              i_wb_ack;
    logic              i_wb_err;

    // master: the LSU itself
    modport master (
        input  i_req, i_we, i_size, i_signed, i_addr, i_data,
        input  i_wb_dat, i_wb_ack, i_wb_err,
        output o_busy, o_done, o_error, o_err_code, o_rdata,
        output o_wb_addr, o_wb_cyc, o_wb_stb, o_wb_we, o_wb_sel, o_wb_dat
    );

    // slave: the CPU stage plus Wishbone slave surrounding the LSU
    modport slave (
        output i_req, i_we, i_size, i_signed, i_addr, i_data,
        output i_wb_dat, i_wb_ack, i_wb_err,
        input  o_busy, o_done, o_error, o_err_code, o_rdata,
        input  o_wb_addr, o_wb_cyc, o_wb_stb, o_wb_we, o_wb_sel, o_wb_dat
    );
endinterface

// File: rtl/wb_lsu.sv
// Wishbone load/store unit: byte/half/word/dword loads and stores with lane select,
// store replication, load extension, misalignment/bus-error/timeout reporting.
// Latency: 2 cycles minimum (accept edge -> bus cycle -> done/error); misaligned errors after 2.
// Backpressure: one transfer at a time; i_req is ignored while o_busy=1, nothing is queued.
// Ports: i_clk, i_reset_n (async active-low), bus (wb_lsu_if.master: CPU + Wishbone signals).
module wb_lsu #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int BIG_ENDIAN = 1,
    parameter int TIMEOUT    = 255
) (
    input  logic      i_clk,
    input  logic      i_reset_n,
    wb_lsu_if.master  bus
);
    localparam int NB = DATA_W / 8;
    localparam int OW = $clog2(NB);
    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    // Counter value at which the abort is taken; cyc then stays up exactly TIMEOUT cycles.
    localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_BUS, ST_FAULT} state_t;

    state_t            state_q, state_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic              sgn_q, sgn_d;
    logic [OW-1:0]     off_q, off_d;
    logic [ADDR_W-1:0] wb_addr_q, wb_addr_d;
    logic              cyc_q, cyc_d;
    logic              wb_we_q, wb_we_d;
    logic [NB-1:0]     sel_q, sel_d;
    logic [DATA_W-1:0] wdat_q, wdat_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic [1:0]        code_q, code_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    // Request decode, from the live request inputs
    logic              misal;
    logic [NB-1:0]     sel_new;
    logic [DATA_W-1:0] wdat_new;
    int                req_bytes, req_off;

    // Load extraction, from latched request and live bus data
    logic [DATA_W-1:0] ld_ext;
    logic              ld_sign;
    int                ld_bytes, ld_off, ld_pos, ld_lane;

    always_comb begin
        misal = 1'b0;
        case (bus.i_size)
            2'b01:   misal = bus.i_addr[0];
            2'b10:   misal = |bus.i_addr[1:0];
            2'b11:   misal = (DATA_W == 32) || (|bus.i_addr[2:0]);
            default: misal = 1'b0;
        endcase
    end

    always_comb begin
        sel_new   = '0;
        wdat_new  = '0;
        req_bytes = 1 << bus.i_size;
        req_off   = int'(bus.i_addr[OW-1:0]);
        for (int b = 0; b < NB; b++) begin
            // b is a byte offset within the bus word; map it to its physical lane
            if (b >= req_off && b < req_off + req_bytes)
                sel_new[(BIG_ENDIAN != 0) ? (NB - 1 - b) : b] = 1'b1;
            // Replication is endian-neutral: lane l always carries byte (l mod size)
            wdat_new[8*b +: 8] = bus.i_data[8*(b % req_bytes) +: 8];
        end
    end

    always_comb begin
        ld_ext   = '0;
        ld_pos   = 0;
        ld_lane  = 0;
        ld_bytes = 1 << size_q;
        if (ld_bytes > NB)
            ld_bytes = NB;
        ld_off   = int'(off_q);
        // Result byte k (k=0 least significant): big-endian puts the MSB at the lowest offset
        for (int k = 0; k < NB; k++) begin
            if (k < ld_bytes) begin
                ld_pos  = (BIG_ENDIAN != 0) ? (ld_off + ld_bytes - 1 - k) : (ld_off + k);
                ld_lane = (BIG_ENDIAN != 0) ? (NB - 1 - ld_pos) : ld_pos;
                ld_ext[8*k +: 8] = bus.i_wb_dat[8*ld_lane +: 8];
            end
        end
        ld_sign = sgn_q & ld_ext[8*ld_bytes-1];
        for (int k = 0; k < NB; k++) begin
            if (k >= ld_bytes)
                ld_ext[8*k +: 8] = {8{ld_sign}};
        end
    end

    always_comb begin
        state_d   = state_q;
        we_d      = we_q;
        size_d    = size_q;
        sgn_d     = sgn_q;
        off_d     = off_q;
        wb_addr_d = wb_addr_q;
        cyc_d     = cyc_q;
        wb_we_d   = wb_we_q;
        sel_d     = sel_q;
        wdat_d    = wdat_q;
        tmo_d     = tmo_q;
        done_d    = 1'b0;
        error_d   = 1'b0;
        code_d    = code_q;
        rdata_d   = rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.i_req) begin
                    we_d      = bus.i_we;
                    size_d    = bus.i_size;
                    sgn_d     = bus.i_signed;
                    off_d     = bus.i_addr[OW-1:0];
                    wb_addr_d = {bus.i_addr[ADDR_W-1:OW], {OW{1'b0}}};
                    if (misal) begin
                        state_d = ST_FAULT;
                    end else begin
                        state_d = ST_BUS;
                        cyc_d   = 1'b1;
                        wb_we_d = bus.i_we;
                        sel_d   = sel_new;
                        wdat_d  = wdat_new;
                        tmo_d   = '0;
                    end
                end
            end
            ST_FAULT: begin
                state_d = ST_IDLE;
                error_d = 1'b1;
                code_d  = 2'b01;
            end
            ST_BUS: begin
                // err takes priority over a simultaneous ack, and leaves o_rdata alone
                if (bus.i_wb_err) begin
                    state_d = ST_IDLE;
                    error_d = 1'b1;
                    code_d  = 2'b10;
                end else if (bus.i_wb_ack) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    if (!we_q)
                        rdata_d = ld_ext;
                end else if ((TIMEOUT != 0) && (tmo_q == TMO_LAST)) begin
                    state_d = ST_IDLE;
                    error_d = 1'b1;
                    code_d  = 2'b11;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
                if (state_d == ST_IDLE) begin
                    cyc_d   = 1'b0;
                    wb_we_d = 1'b0;
                    sel_d   = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q   <= ST_IDLE;
            we_q      <= 1'b0;
            size_q    <= 2'b00;
            sgn_q     <= 1'b0;
            off_q     <= '0;
            wb_addr_q <= '0;
            cyc_q     <= 1'b0;
            wb_we_q   <= 1'b0;
            sel_q     <= '0;
            wdat_q    <= '0;
            tmo_q     <= '0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            code_q    <= 2'b00;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            we_q      <= we_d;
            size_q    <= size_d;
            sgn_q     <= sgn_d;
            off_q     <= off_d;
            wb_addr_q <= wb_addr_d;
            cyc_q     <= cyc_d;
            wb_we_q   <= wb_we_d;
            sel_q     <= sel_d;
            wdat_q    <= wdat_d;
            tmo_q     <= tmo_d;
            done_q    <= done_d;
            error_q   <= error_d;
            code_q    <= code_d;
            rdata_q   <= rdata_d;
        end
    end

    assign bus.o_busy     = (state_q != ST_IDLE);
    assign bus.o_done     = done_q;
    assign bus.o_error    = error_q;
    assign bus.o_err_code = code_q;
    assign bus.o_rdata    = rdata_q;
    assign bus.o_wb_addr  = wb_addr_q;
    assign bus.o_wb_cyc   = cyc_q;
    assign bus.o_wb_stb   = cyc_q;
    assign bus.o_wb_we    = wb_we_q;
    assign bus.o_wb_sel   = sel_q;
    assign bus.o_wb_dat   = wdat_q;
endmodule

// File: tb/tb_wb_lsu.sv
// Directed bench for wb_lsu: a 32-bit big-endian instance (TIMEOUT=4) and a
// 64-bit little-endian instance (TIMEOUT=255); expected terminations are queued
// when a request is issued and popped when the DUT reports done/error.
module tb_wb_lsu;
    logic clk = 1'b0;
    logic rst32_n;
    logic rst64_n;

    always #5 clk = ~clk;

    wb_lsu_if #(.ADDR_W(32), .DATA_W(32)) if32 ();
    wb_lsu_if #(.ADDR_W(32), .DATA_W(64)) if64 ();

    wb_lsu #(.ADDR_W(32), .DATA_W(32), .BIG_ENDIAN(1), .TIMEOUT(4)) u_dut32 (
        .i_clk(clk), .i_reset_n(rst32_n), .bus(if32.master));
    wb_lsu #(.ADDR_W(32), .DATA_W(64), .BIG_ENDIAN(0), .TIMEOUT(255)) u_dut64 (
        .i_clk(clk), .i_reset_n(rst64_n), .bus(if64.master));

    typedef struct {
        string       tag;
        bit          is_err;
        logic [1:0]  code;
        bit          chk_rd;
        logic [63:0] rd;
        int          lat;
        int          cyc_hi;
    } exp_t;

    exp_t sbq[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input string tag, input bit is_err, input logic [1:0] code,
                            input bit chk_rd, input logic [63:0] rd, input int lat,
                            input int cyc_hi);
        exp_t e;
        e.tag = tag; e.is_err = is_err; e.code = code; e.chk_rd = chk_rd;
        e.rd = rd; e.lat = lat; e.cyc_hi = cyc_hi;
        sbq.push_back(e);
    endtask

    // Drives one request for a cycle; returns in the cycle after the accepting edge.
    task automatic drive_req(input bit u, input bit we, input logic [1:0] sz, input bit sg,
                             input logic [31:0] a, input logic [63:0] d);
        if (u) begin
            if64.i_we = we; if64.i_size = sz; if64.i_signed = sg;
            if64.i_addr = a; if64.i_data = d; if64.i_req = 1'b1;
        end else begin
            if32.i_we = we; if32.i_size = sz; if32.i_signed = sg;
            if32.i_addr = a; if32.i_data = d[31:0]; if32.i_req = 1'b1;
        end
        step();
        if32.i_req = 1'b0;
        if64.i_req = 1'b0;
    endtask

    // Waits, then presents ack/err for one cycle; returns in the cycle after that edge.
    task automatic drive_resp(input bit u, input int waits, input bit ack, input bit err,
                              input logic [63:0] d);
        repeat (waits) step();
        if (u) begin
            if64.i_wb_ack = ack; if64.i_wb_err = err; if64.i_wb_dat = d;
        end else begin
            if32.i_wb_ack = ack; if32.i_wb_err = err; if32.i_wb_dat = d[31:0];
        end
        step();
        if32.i_wb_ack = 1'b0; if32.i_wb_err = 1'b0;
        if64.i_wb_ack = 1'b0; if64.i_wb_err = 1'b0;
    endtask

    task automatic snap(input bit u, output logic dn, output logic er, output logic cy,
                        output logic [1:0] cd, output logic [63:0] rd);
        if (u) begin
            dn = if64.o_done; er = if64.o_error; cy = if64.o_wb_cyc;
            cd = if64.o_err_code; rd = if64.o_rdata;
        end else begin
            dn = if32.o_done; er = if32.o_error; cy = if32.o_wb_cyc;
            cd = if32.o_err_code; rd = {32'h0, if32.o_rdata};
        end
    endtask

    task automatic expect_end(input bit u, input int budget);
        exp_t        e;
        int          c = 0;
        int          hi = 0;
        logic        dn, er, cy;
        logic [1:0]  cd;
        logic [63:0] rd;
        snap(u, dn, er, cy, cd, rd);
        while (!(dn || er) && c < budget) begin
            if (cy) hi++;
            step();
            c++;
            snap(u, dn, er, cy, cd, rd);
        end
        if (sbq.size() == 0) begin
            check("sb_underflow", 64'd0, 64'd1);
        end else begin
            e = sbq.pop_front();
            check({e.tag, "_term"}, {62'd0, dn, er}, {62'd0, !e.is_err, e.is_err});
            check({e.tag, "_both"}, {63'd0, dn & er}, 64'd0);
            if (e.is_err) check({e.tag, "_code"}, {62'd0, cd}, {62'd0, e.code});
            if (e.chk_rd) check({e.tag, "_rdata"}, rd, e.rd);
            check({e.tag, "_lat"}, 64'(c), 64'(e.lat));
            check({e.tag, "_cychi"}, 64'(hi), 64'(e.cyc_hi));
        end
    endtask

    task automatic check_bus32(input string tag, input bit we, input logic [3:0] sel,
                               input logic [31:0] addr, input logic [31:0] dat, input bit chk_dat);
        check({tag, "_cyc"}, {61'd0, if32.o_wb_cyc, if32.o_wb_stb, if32.o_busy}, 64'h7);
        check({tag, "_we"}, {63'd0, if32.o_wb_we}, {63'd0, we});
        check({tag, "_sel"}, {60'd0, if32.o_wb_sel}, {60'd0, sel});
        check({tag, "_addr"}, {32'd0, if32.o_wb_addr}, {32'd0, addr});
        if (chk_dat) check({tag, "_dat"}, {32'd0, if32.o_wb_dat}, {32'd0, dat});
    endtask

    task automatic check_bus64(input string tag, input bit we, input logic [7:0] sel,
                               input logic [31:0] addr, input logic [63:0] dat, input bit chk_dat);
        check({tag, "_cyc"}, {61'd0, if64.o_wb_cyc, if64.o_wb_stb, if64.o_busy}, 64'h7);
        check({tag, "_we"}, {63'd0, if64.o_wb_we}, {63'd0, we});
        check({tag, "_sel"}, {56'd0, if64.o_wb_sel}, {56'd0, sel});
        check({tag, "_addr"}, {32'd0, if64.o_wb_addr}, {32'd0, addr});
        if (chk_dat) check({tag, "_dat"}, if64.o_wb_dat, dat);
    endtask

    initial begin
        int quiet;
        if32.i_req = 0; if32.i_we = 0; if32.i_size = 0; if32.i_signed = 0;
        if32.i_addr = 0; if32.i_data = 0; if32.i_wb_dat = 0; if32.i_wb_ack = 0; if32.i_wb_err = 0;
        if64.i_req = 0; if64.i_we = 0; if64.i_size = 0; if64.i_signed = 0;
        if64.i_addr = 0; if64.i_data = 0; if64.i_wb_dat = 0; if64.i_wb_ack = 0; if64.i_wb_err = 0;
        rst32_n = 1'b0;
        rst64_n = 1'b0;
        step();
        step();

        // Reset values
        check("rst32_bus", {57'd0, if32.o_wb_cyc, if32.o_wb_stb, if32.o_wb_we, if32.o_wb_sel}, 64'd0);
        check("rst32_addr", {32'd0, if32.o_wb_addr}, 64'd0);
        check("rst32_dat", {32'd0, if32.o_wb_dat}, 64'd0);
        check("rst32_stat", {59'd0, if32.o_busy, if32.o_done, if32.o_error, if32.o_err_code}, 64'd0);
        check("rst32_rdata", {32'd0, if32.o_rdata}, 64'd0);
        check("rst64_bus", {53'd0, if64.o_wb_cyc, if64.o_wb_stb, if64.o_wb_we, if64.o_wb_sel}, 64'd0);
        check("rst64_dat", if64.o_wb_dat, 64'd0);
        check("rst64_stat", {59'd0, if64.o_busy, if64.o_done, if64.o_error, if64.o_err_code}, 64'd0);
        rst32_n = 1'b1;
        rst64_n = 1'b1;
        step();

        // 32-bit BE: byte store, zero-wait ack, only the low byte of i_data is used
        push_exp("st_b", 0, 2'b00, 0, 64'd0, 0, 0);
        drive_req(0, 1, 2'b00, 0, 32'h1001, 64'h123456A5);
        check_bus32("st_b", 1, 4'b0100, 32'h1000, 32'hA5A5A5A5, 1);
        drive_resp(0, 0, 1, 0, 64'd0);
        expect_end(0, 20);
        check("st_b_cycdrop", {63'd0, if32.o_wb_cyc | if32.o_busy}, 64'd0);
        step();
        check("st_b_pulse", {62'd0, if32.o_done, if32.o_error}, 64'd0);

        // Halfword store at offset 2
        push_exp("st_h", 0, 2'b00, 0, 64'd0, 0, 0);
        drive_req(0, 1, 2'b01, 0, 32'h1002, 64'h0000BEEF);
        check_bus32("st_h", 1, 4'b0011, 32'h1000, 32'hBEEFBEEF, 1);
        drive_resp(0, 1, 1, 0, 64'd0);
        expect_end(0, 20);

        // Signed / unsigned halfword loads with wait states
        push_exp("ld_hs", 0, 2'b00, 1, 64'hFFFFF00D, 0, 0);
        drive_req(0, 0, 2'b01, 1, 32'h2002, 64'd0);
        check_bus32("ld_hs", 0, 4'b0011, 32'h2000, 32'h0, 0);
        drive_resp(0, 2, 1, 0, 64'h1234F00D);
        expect_end(0, 20);

        push_exp("ld_hu", 0, 2'b00, 1, 64'h0000F00D, 0, 0);
        drive_req(0, 0, 2'b01, 0, 32'h2002, 64'd0);
        drive_resp(0, 0, 1, 0, 64'h1234F00D);
        expect_end(0, 20);

        // Signed byte at offset 0 lives in the top lane
        push_exp("ld_bs", 0, 2'b00, 1, 64'hFFFFFF80, 0, 0);
        drive_req(0, 0, 2'b00, 1, 32'h3000, 64'd0);
        check_bus32("ld_bs", 0, 4'b1000, 32'h3000, 32'h0, 0);
        drive_resp(0, 0, 1, 0, 64'h80123456);
        expect_end(0, 20);

        push_exp("ld_w", 0, 2'b00, 1, 64'h89ABCDEF, 0, 0);
        drive_req(0, 0, 2'b10, 1, 32'h3004, 64'd0);
        check_bus32("ld_w", 0, 4'b1111, 32'h3004, 32'h0, 0);
        drive_resp(0, 0, 1, 0, 64'h89ABCDEF);
        expect_end(0, 20);

        // Timeout: cyc high exactly 4 cycles, rdata keeps the last load
        push_exp("tmo", 1, 2'b11, 1, 64'h89ABCDEF, 4, 4);
        drive_req(0, 0, 2'b10, 0, 32'h4000, 64'd0);
        expect_end(0, 20);

        // ack and err together: err wins, then a request in the error cycle
        push_exp("ackerr", 1, 2'b10, 1, 64'h89ABCDEF, 0, 0);
        drive_req(0, 0, 2'b10, 0, 32'h5000, 64'd0);
        drive_resp(0, 0, 1, 1, 64'hFFFFFFFF);
        expect_end(0, 20);
        push_exp("b2b", 0, 2'b00, 0, 64'd0, 0, 0);
        drive_req(0, 1, 2'b10, 0, 32'h6000, 64'hCAFEF00D);
        check_bus32("b2b", 1, 4'b1111, 32'h6000, 32'hCAFEF00D, 1);
        drive_resp(0, 0, 1, 0, 64'd0);
        expect_end(0, 20);
        check("code_held", {62'd0, if32.o_err_code}, 64'h2);

        // Misaligned half and illegal dword on a 32-bit bus
        push_exp("mis_h", 1, 2'b01, 0, 64'd0, 1, 0);
        drive_req(0, 1, 2'b01, 0, 32'h1001, 64'h1111);
        expect_end(0, 20);
        push_exp("ill_d", 1, 2'b01, 0, 64'd0, 1, 0);
        drive_req(0, 0, 2'b11, 0, 32'h1000, 64'd0);
        expect_end(0, 20);

        // Requests while busy are ignored
        push_exp("busy_ld", 0, 2'b00, 1, 64'h0BADF00D, 0, 0);
        drive_req(0, 0, 2'b10, 0, 32'h7000, 64'd0);
        if32.i_req = 1'b1; if32.i_we = 1'b1; if32.i_addr = 32'h8000; if32.i_size = 2'b10;
        step();
        step();
        check_bus32("busy_hold", 0, 4'b1111, 32'h7000, 32'h0, 0);
        if32.i_req = 1'b0;
        drive_resp(0, 0, 1, 0, 64'h0BADF00D);
        expect_end(0, 20);
        quiet = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (if32.o_done || if32.o_error || if32.o_busy) quiet++;
        end
        check("busy_single", 64'(quiet), 64'd0);

        // Asynchronous reset in the middle of a bus cycle
        drive_req(0, 0, 2'b10, 0, 32'h9000, 64'd0);
        check("rstmid_cyc_up", {63'd0, if32.o_wb_cyc}, 64'd1);
        #2;
        rst32_n = 1'b0;
        #1;
        check("rstmid_cyc_drop", {62'd0, if32.o_wb_cyc, if32.o_busy}, 64'd0);
        step();
        rst32_n = 1'b1;
        quiet = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (if32.o_done || if32.o_error || if32.o_wb_cyc) quiet++;
        end
        check("rstmid_quiet", 64'(quiet), 64'd0);
        check("rstmid_rdata", {32'd0, if32.o_rdata}, 64'd0);

        // 64-bit LE: word store at offset 4
        push_exp("st64_w", 0, 2'b00, 0, 64'd0, 0, 0);
        drive_req(1, 1, 2'b10, 0, 32'h104, 64'h11111111DEADBEEF);
        check_bus64("st64_w", 1, 8'hF0, 32'h100, 64'hDEADBEEFDEADBEEF, 1);
        drive_resp(1, 0, 1, 0, 64'd0);
        expect_end(1, 20);

        // Dword at offset 4 is misaligned and never reaches the bus
        push_exp("mis64_d", 1, 2'b01, 0, 64'd0, 1, 0);
        drive_req(1, 1, 2'b11, 0, 32'h104, 64'h0);
        expect_end(1, 20);

        push_exp("st64_b", 0, 2'b00, 0, 64'd0, 0, 0);
        drive_req(1, 1, 2'b00, 0, 32'h103, 64'hFFFFFFFFFFFFFF5A);
        check_bus64("st64_b", 1, 8'h08, 32'h100, 64'h5A5A5A5A5A5A5A5A, 1);
        drive_resp(1, 0, 1, 0, 64'd0);
        expect_end(1, 20);

        push_exp("ld64_d", 0, 2'b00, 1, 64'h0123456789ABCDEF, 0, 0);
        drive_req(1, 0, 2'b11, 0, 32'h108, 64'd0);
        check_bus64("ld64_d", 0, 8'hFF, 32'h108, 64'd0, 0);
        drive_resp(1, 1, 1, 0, 64'h0123456789ABCDEF);
        expect_end(1, 20);

        push_exp("ld64_hs", 0, 2'b00, 1, 64'hFFFFFFFFFFFF8001, 0, 0);
        drive_req(1, 0, 2'b01, 1, 32'h10E, 64'd0);
        check_bus64("ld64_hs", 0, 8'hC0, 32'h108, 64'd0, 0);
        drive_resp(1, 0, 1, 0, 64'h8001000000000000);
        expect_end(1, 20);

        push_exp("ld64_ws", 0, 2'b00, 1, 64'hFFFFFFFFF0000000, 0, 0);
        drive_req(1, 0, 2'b10, 1, 32'h104, 64'd0);
        drive_resp(1, 0, 1, 0, 64'hF000000012345678);
        expect_end(1, 20);

        check("sb_drained", 64'(sbq.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
